// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the execute/memory slice: ALU op codes, load/store width codes,
// LSU FSM states and access-legality helpers.
package load_store_unit_pkg;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {StIdle, StBus, StResp} lsu_state_e;

  function automatic logic lsu_legal(logic we, logic [2:0] funct3);
    logic ok;
    if (we) ok = funct3 inside {LSU_B, LSU_H, LSU_W};
    else    ok = funct3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU};
    return ok;
  endfunction

  // funct3[1:0] encodes the access size for both signed and unsigned loads.
  function automatic logic lsu_misaligned(logic [2:0] funct3, logic [1:0] offset);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = offset[0];
      2'b10:   mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store byte enables and data replication, load lane extraction and extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    if (we) begin
      case (funct3)
        LSU_B: begin
          wstrb     = 4'b0001 << offset;
          wdata_rep = {4{wdata[7:0]}};
        end
        LSU_H: begin
          wstrb     = 4'b0011 << offset;
          wdata_rep = {2{wdata[15:0]}};
        end
        default: wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    lane_b    = rdata[{offset, 3'b000} +: 8];
    lane_h    = rdata[{offset[1], 4'b0000} +: 16];
    rdata_ext = rdata;
    case (funct3)
      LSU_B:   rdata_ext = {{24{lane_b[7]}}, lane_b};
      LSU_H:   rdata_ext = {{16{lane_h[15]}}, lane_h};
      LSU_BU:  rdata_ext = {24'h0, lane_b};
      LSU_HU:  rdata_ext = {16'h0, lane_h};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one op, runs one bus transaction with a
// timeout, and returns a one-cycle completion pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [4:0]      rd_q;
  logic [31:0]     load_ext;

  // Steering runs off the captured request so bus outputs stay stable while waiting.
  lsu_align u_align (
    .we        (we_q),
    .funct3    (funct3_q),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .wstrb     (mem_wstrb),
    .wdata_rep (mem_wdata),
    .rdata_ext (load_ext)
  );

  assign req_ready = (state_q == StIdle);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign rsp_rd    = rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rd_q      <= 5'h0;
      mem_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rd_q     <= req_rd;
            cnt_q    <= '0;
            if (lsu_legal(req_we, req_funct3) && !lsu_misaligned(req_funct3, req_addr[1:0])) begin
              state_q   <= StBus;
              mem_valid <= 1'b1;
            end else begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end
          end
        end
        StBus: begin
          if (mem_ready) begin
            state_q   <= StResp;
            mem_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_q ? 32'h0 : load_ext;
          end else if (cnt_q == CntLast) begin
            state_q   <= StResp;
            mem_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          rsp_valid <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a per-cycle expectation schedule built from the
// access rules, checked by one compare process, plus directed corner cases.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_rd     (rsp_rd),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        full;
    logic        ready;
    logic        mv;
    logic [31:0] maddr;
    logic [3:0]  wstrb;
    logic        wchk;
    logic [31:0] wdata;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
    logic [4:0]  rd;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cycle_n, act, want);
    end
  endtask

  // Reference rules
  function automatic bit m_legal(bit we, bit [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 != 3'd3) && (f3 <= 3'd5);
  endfunction

  function automatic int m_bytes(bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_misaligned(bit [2:0] f3, bit [31:0] a);
    return (a % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_wstrb(bit [2:0] f3, bit [31:0] a);
    int v;
    v = ((1 << m_bytes(f3)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(bit [2:0] f3, bit [31:0] wd);
    logic [31:0] r;
    int n = m_bytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(bit [2:0] f3, bit [31:0] a, bit [31:0] rd);
    logic [31:0] v, mask;
    int n = m_bytes(f3);
    v = rd >> (8 * (a % 4));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic exp_t e_idle();
    exp_t e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  // Each call covers one clock cycle: inputs already set by the caller, e = outputs now.
  task automatic cyc(input exp_t e);
    expq.push_back(e);
    @(posedge clk);
    #1;
    cycle_n++;
  endtask

  task automatic junk();
    req_valid  = 1'($urandom);
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom);
    mem_ready  = 1'($urandom);
    mem_rdata  = $urandom;
  endtask

  task automatic do_txn(input bit we, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] wd, input bit [4:0] rd, input int lat,
                        input bit [31:0] rdat);
    exp_t e;
    bit   bad;
    int   nb;
    bad = !m_legal(we, f3) || m_misaligned(f3, a);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    cyc(e_idle());
    junk();
    if (!bad) begin
      nb = (lat <= TMO) ? lat : TMO;
      for (int j = 1; j <= nb; j++) begin
        mem_ready = (j == lat);
        mem_rdata = (j == lat) ? rdat : $urandom;
        e       = '0;
        e.mv    = 1'b1;
        e.maddr = a & ~32'h3;
        e.wstrb = we ? m_wstrb(f3, a) : 4'h0;
        e.wchk  = we;
        e.wdata = m_wdata(f3, wd);
        cyc(e);
        junk();
      end
    end
    e       = '0;
    e.rv    = 1'b1;
    e.err   = bad || (lat > TMO);
    e.rdata = (e.err || we) ? 32'h0 : m_load(f3, a, rdat);
    e.rd    = rd;
    cyc(e);
    req_valid = 1'b0;
  endtask

  // Compare process
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("req_ready", 32'(req_ready), 32'(e.ready));
        chk("mem_valid", 32'(mem_valid), 32'(e.mv));
        chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
        if (e.mv) begin
          chk("mem_addr", mem_addr, e.maddr);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
          if (e.wchk) chk("mem_wdata", mem_wdata, e.wdata);
        end
        if (e.full) chk("reset_wstrb", 32'(mem_wstrb), 32'h0);
        if (e.rv || e.full) begin
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    exp_t e;
    bit [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bit       we;
    bit [2:0] f3;
    bit [31:0] a;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_rd = 5'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    @(posedge clk);
    #1;
    e = e_idle(); e.full = 1'b1;
    cyc(e);
    rst = 1'b0;
    cyc(e);

    // Model pins against hand-computed values
    chk("pin_lw", m_load(3'b010, 32'h100, 32'hDEADBEEF), 32'hDEADBEEF);
    chk("pin_lb", m_load(3'b000, 32'h103, 32'h80FF0000), 32'hFFFFFF80);
    chk("pin_lbu", m_load(3'b100, 32'h103, 32'h80FF0000), 32'h00000080);
    chk("pin_sh_strb", 32'(m_wstrb(3'b001, 32'h202)), 32'hC);
    chk("pin_sh_data", m_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);
    chk("pin_sb_strb", 32'(m_wstrb(3'b000, 32'h201)), 32'h2);
    chk("pin_mis", 32'(m_misaligned(3'b010, 32'h101)), 32'h1);

    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 3, 32'hDEADBEEF);
    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 5'd4, 1, 32'h80FF0000);
    do_txn(1'b0, 3'b100, 32'h103, 32'h0, 5'd5, 2, 32'h80FF0000);
    do_txn(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd6, 2, 32'h0);
    do_txn(1'b0, 3'b010, 32'h101, 32'h0, 5'd8, 1, 32'h0);
    do_txn(1'b0, 3'b011, 32'h100, 32'h0, 5'd9, 1, 32'h0);
    do_txn(1'b1, 3'b100, 32'h100, 32'h0, 5'd10, 1, 32'h0);
    do_txn(1'b0, 3'b010, 32'h400, 32'h0, 5'd11, 100, 32'h0);
    do_txn(1'b0, 3'b101, 32'h402, 32'h0, 5'd12, TMO, 32'h8001_7FFF);

    // Reset while waiting on the bus
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_rd = 5'd7;
    mem_ready = 1'b0;
    cyc(e_idle());
    req_valid = 1'b0;
    e = '0; e.mv = 1'b1; e.maddr = 32'h300; e.wstrb = 4'h0;
    cyc(e);
    rst = 1'b1;
    cyc(e);
    rst = 1'b0;
    e = e_idle(); e.full = 1'b1;
    cyc(e);
    cyc(e_idle());

    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(m_bytes(f3)) - 32'h1);
      do_txn(we, f3, a, $urandom, 5'($urandom), $urandom_range(1, TMO + 2), $urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        req_valid = 1'b0; mem_ready = 1'($urandom); mem_rdata = $urandom;
        cyc(e_idle());
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles spent waiting for mem_ready before aborting.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: execute stage presents a memory op.
REQ-005 SHALL have port req_ready, output, 1 bit: unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits: RV32I load/store width code.
REQ-008 SHALL have port req_addr, input, 32 bits: effective address (ALU add result).
REQ-009 SHALL have port req_wdata, input, 32 bits: store data (rs2).
REQ-010 SHALL have port req_rd, input, 5 bits: destination register tag.
REQ-011 SHALL have port mem_valid, output, 1 bit: bus request.
REQ-012 SHALL have port mem_ready, input, 1 bit: bus completes the request.
REQ-013 SHALL have port mem_addr, output, 32 bits: word-aligned address (req_addr with bits [1:0] = 0).
REQ-014 SHALL have port mem_wstrb, output, 4 bits: byte enables; 0000 for loads.
REQ-015 SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-016 SHALL have port mem_rdata, input, 32 bits: read data, valid when mem_ready = 1.
REQ-017 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-019 SHALL have port rsp_rd, output, 5 bits: captured req_rd.
REQ-020 SHALL have port rsp_err, output, 1 bit: misaligned access, illegal funct3, or timeout.

Function
REQ-021 SHALL implement an FSM with states IDLE, BUS and RESP; req_ready = 1 only in IDLE.
REQ-022 SHALL, on req_valid & req_ready, register we, funct3, addr, wdata and rd, then go to BUS when legal and RESP with err = 1 otherwise.
REQ-023 SHALL treat legal load funct3 as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and legal store funct3 as 000 SB, 001 SH, 010 SW; all other codes are illegal.
REQ-024 SHALL flag misalignment as: half-word with addr[0] = 1, or word with addr[1:0] != 00; a misaligned access SHALL issue no bus transaction.
REQ-025 SHALL, in BUS, hold mem_valid = 1 with addr, wstrb and wdata stable until mem_ready = 1.
REQ-026 SHALL, on mem_ready = 1, capture the extended rdata and go to RESP.
REQ-027 SHALL drive mem_valid = 0 in IDLE and RESP.
REQ-028 SHALL generate mem_wstrb as: SB = 0001 << addr[1:0]; SH = 0011 << addr[1:0]; SW = 1111.
REQ-029 SHALL generate mem_wdata as: SB = byte replicated x4; SH = half-word replicated x2; SW = as-is.
REQ-030 SHALL extract load data from lane addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend.
REQ-031 SHALL count BUS cycles; when mem_ready is still 0 after TIMEOUT cycles, drop mem_valid and go to RESP with err = 1.
REQ-032 SHALL, in RESP, assert rsp_valid for exactly one cycle, then return to IDLE with no back-pressure.
REQ-033 SHALL meet this latency: accept in cycle N, mem_valid in N+1; mem_ready in cycle M gives rsp_valid in M+1; an error accept gives rsp_valid in N+1.
REQ-034 SHALL ignore req_valid while not in IDLE; back-to-back requests are accepted in the cycle after rsp_valid.

Reset
REQ-035 SHALL, on rst = 1 at a clock edge, enter IDLE and zero the timeout counter, with mem_valid = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, rsp_rd = 0, mem_wstrb = 0000, and req_ready = 1 after release.
REQ-036 SHALL abandon any in-flight transaction when reset is asserted mid-operation, with no rsp_valid pulse.

Structure
REQ-037 SHALL take its funct3 width codes (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) from the shared definitions file alongside the ALU op codes.
REQ-038 SHALL place lane steering (wstrb, wdata replication, load extraction and extension) in a combinational sub-module named lsu_align.

Verification
REQ-039 SHALL cover: LW at 0x100, mem_rdata = 0xDEADBEEF, mem_ready after 3 cycles -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, single rsp_valid pulse.
REQ-040 SHALL cover: LB at 0x103, rdata = 0x80FF_0000 -> rsp_rdata = 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-041 SHALL cover: SH at 0x202, wdata = 0x1234ABCD -> mem_addr = 0x200, mem_wstrb = 1100, mem_wdata = 0xABCDABCD.
REQ-042 SHALL cover: LW at 0x101 and funct3 = 011 -> rsp_err = 1 in cycle N+1, mem_valid never asserted.
REQ-043 SHALL cover: mem_ready held at 0 with TIMEOUT = 4 -> mem_valid drops after 4 BUS cycles, then rsp_err = 1.
REQ-044 SHALL cover: rst asserted during BUS -> next cycle mem_valid = 0, req_ready = 1, no rsp_valid.
